// File: rtl/kbd_pkg.sv
// Shared key codes and controller state type for the keyboard-to-servo-target path.
// Home-key decode is enabled by defining KBD_HOME_KEY_EN.
package kbd_pkg;

    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] KEY_W_LO = 8'h77;
    localparam logic [BYTE_W-1:0] KEY_W_UP = 8'h57;
    localparam logic [BYTE_W-1:0] KEY_S_LO = 8'h73;
    localparam logic [BYTE_W-1:0] KEY_S_UP = 8'h53;
    localparam logic [BYTE_W-1:0] KEY_D_LO = 8'h64;
    localparam logic [BYTE_W-1:0] KEY_D_UP = 8'h44;
    localparam logic [BYTE_W-1:0] KEY_A_LO = 8'h61;
    localparam logic [BYTE_W-1:0] KEY_A_UP = 8'h41;
    localparam logic [BYTE_W-1:0] KEY_H_LO = 8'h68;
    localparam logic [BYTE_W-1:0] KEY_H_UP = 8'h48;

    typedef enum logic {
        IDLE,
        EXEC
    } kbd_state_t;

endpackage

// File: rtl/kbd_cmd_fifo.sv
// Single-clock command FIFO; the head entry is read straight from the register array.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module kbd_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             wr_en;
    logic             rd_en;

    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and the decoded empty/full flags, all registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/kbd_target_ctrl.sv
// Buffers received key bytes and steps bounded X/Y servo targets, one command per two cycles.
// Define KBD_HOME_KEY_EN to make h/H return both coordinates to their home values.
module kbd_target_ctrl
    import kbd_pkg::*;
#(
    parameter int unsigned COORD_W    = 8,
    parameter int unsigned X_MIN      = 1,
    parameter int unsigned X_MAX      = 4,
    parameter int unsigned Y_MIN      = 1,
    parameter int unsigned Y_MAX      = 4,
    parameter int unsigned X_HOME     = 2,
    parameter int unsigned Y_HOME     = 4,
    parameter int unsigned WRAP       = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               clr_ovf,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               moved,
    output logic               at_limit,
    output logic               overflow,
    output logic               fifo_empty
);

    localparam int unsigned EXT_W = COORD_W + 1;

    localparam logic [COORD_W-1:0] X_LO = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] X_HI = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LO = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_HI = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] X_HM = COORD_W'(X_HOME);
    localparam logic [COORD_W-1:0] Y_HM = COORD_W'(Y_HOME);

    kbd_state_t                  state;
    kbd_state_t                  state_nxt;
    logic [BYTE_W-1:0]           cmd;
    logic [BYTE_W-1:0]           cmd_nxt;
    logic [COORD_W-1:0]          x_nxt;
    logic [COORD_W-1:0]          y_nxt;
    logic                        moved_nxt;
    logic                        at_limit_nxt;
    logic [COORD_W:0]            step_r;
    logic                        pop_c;
    logic                        drop_c;
    logic [BYTE_W-1:0]           fifo_dout;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                        fifo_full;

    // One step toward a limit; result is {blocked, next}. Extended width keeps MIN==0 safe.
    function automatic logic [COORD_W:0] step_coord(
        input logic [COORD_W-1:0] cur,
        input logic               up,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        logic [EXT_W-1:0]   ext;
        logic [COORD_W-1:0] res;
        logic               blocked;
        ext     = {1'b0, cur};
        blocked = 1'b0;
        if (up) begin
            if (ext >= {1'b0, hi}) begin
                res     = (WRAP != 0) ? lo : hi;
                blocked = (WRAP == 0);
            end else begin
                res = COORD_W'(ext + EXT_W'(1));
            end
        end else begin
            if (ext <= {1'b0, lo}) begin
                res     = (WRAP != 0) ? hi : lo;
                blocked = (WRAP == 0);
            end else begin
                res = COORD_W'(ext - EXT_W'(1));
            end
        end
        return {blocked, res};
    endfunction

    kbd_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (pop_c),
        .din   (rx_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign drop_c = rx_valid && fifo_full && !pop_c;

    always_comb begin
        state_nxt    = state;
        cmd_nxt      = cmd;
        x_nxt        = x;
        y_nxt        = y;
        moved_nxt    = 1'b0;
        at_limit_nxt = 1'b0;
        pop_c        = 1'b0;
        step_r       = '0;
        case (state)
            IDLE: begin
                if (fifo_count != '0) begin
                    pop_c     = 1'b1;
                    cmd_nxt   = fifo_dout;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                state_nxt = IDLE;
                case (cmd)
                    KEY_W_LO, KEY_W_UP: begin
                        step_r       = step_coord(y, 1'b1, Y_LO, Y_HI);
                        y_nxt        = step_r[COORD_W-1:0];
                        at_limit_nxt = step_r[COORD_W];
                    end
                    KEY_S_LO, KEY_S_UP: begin
                        step_r       = step_coord(y, 1'b0, Y_LO, Y_HI);
                        y_nxt        = step_r[COORD_W-1:0];
                        at_limit_nxt = step_r[COORD_W];
                    end
                    KEY_D_LO, KEY_D_UP: begin
                        step_r       = step_coord(x, 1'b1, X_LO, X_HI);
                        x_nxt        = step_r[COORD_W-1:0];
                        at_limit_nxt = step_r[COORD_W];
                    end
                    KEY_A_LO, KEY_A_UP: begin
                        step_r       = step_coord(x, 1'b0, X_LO, X_HI);
                        x_nxt        = step_r[COORD_W-1:0];
                        at_limit_nxt = step_r[COORD_W];
                    end
`ifdef KBD_HOME_KEY_EN
                    KEY_H_LO, KEY_H_UP: begin
                        x_nxt = X_HM;
                        y_nxt = Y_HM;
                    end
`else
`endif
                    default: ;
                endcase
                // Pulse only on a real change; wrap with MIN==MAX therefore stays quiet
                moved_nxt = (x_nxt != x) || (y_nxt != y);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cmd      <= '0;
            x        <= X_HM;
            y        <= Y_HM;
            moved    <= 1'b0;
            at_limit <= 1'b0;
        end else begin
            state    <= state_nxt;
            cmd      <= cmd_nxt;
            x        <= x_nxt;
            y        <= y_nxt;
            moved    <= moved_nxt;
            at_limit <= at_limit_nxt;
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop_c) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

endmodule
